logic_op_arbiter: RTL

Shared-resource scheduler for the bitwise logic-operation datapath. Up to NREQ requesters submit (opcode, A, B) transactions over valid/ready handshakes. A round-robin arbiter grants one requester at a time, and the block runs the operation on a single registered logic unit. It returns the result with the requester ID over a valid/ready response port. It sits between client blocks and the logic-op datapath so that the datapath exists once, not once per client.

---
 rtl/logic_op_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/logic_op_arbiter.sv
// ---------------------------------------------------------------------------
// logic_op_arbiter
//
// Shares one registered bitwise logic unit between NREQ requesters. A
// round-robin arbiter accepts one (op, A, B) request at a time. The block
// computes the result, then returns it with the owning requester's ID over a
// valid/ready response port.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   rst_n      - asynchronous active-low reset
//   req_valid  - [NREQ] per-requester request valid
//   req_ready  - [NREQ] per-requester accept, at most one bit high
//   req_op     - [3*NREQ] opcode, requester i at [3i+2:3i]
//   req_a      - [WIDTH*NREQ] operand A, requester i at [WIDTH*i +: WIDTH]
//   req_b      - [WIDTH*NREQ] operand B, same packing as req_a
//   rsp_valid  - response valid
//   rsp_ready  - response consumer ready
//   rsp_data   - [WIDTH] operation result
//   rsp_id     - [IDW] requester that owns rsp_data
//   busy       - high while a transaction is in flight (EXEC or RESP)
//   done_cnt   - [16] completed-response counter, wraps silently
//
// Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 BUF A.
// ---------------------------------------------------------------------------
module logic_op_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy,
  output logic [15:0]           done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic [15:0]      done_cnt_q, done_cnt_d;

  logic             gnt_found;
  int               gnt_int;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] alu_res;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  // past NREQ-1 back to 0. Works for non-power-of-two NREQ.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_int   = 0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_int   = idx;
      end
    end
    gnt_idx = IDW'(gnt_int);
  end

  // Single shared logic unit, fed only from the captured operand registers
  // so that requester inputs cannot disturb an in-flight operation.
  always_comb begin
    alu_res = '0;
    case (op_q)
      3'd0: alu_res = a_q & b_q;
      3'd1: alu_res = a_q | b_q;
      3'd2: alu_res = ~(a_q & b_q);
      3'd3: alu_res = ~(a_q | b_q);
      3'd4: alu_res = a_q ^ b_q;
      3'd5: alu_res = ~(a_q ^ b_q);
      3'd6: alu_res = ~a_q;
      default: alu_res = a_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          op_d     = req_op[3*gnt_int +: 3];
          a_d      = req_a[WIDTH*gnt_int +: WIDTH];
          b_d      = req_b[WIDTH*gnt_int +: WIDTH];
          gnt_id_d = gnt_idx;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_data_d = alu_res;
        rsp_id_d   = gnt_id_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          // Pointer moves only on completion, to the slot after the winner.
          rr_ptr_d   = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered decodes of the next state keep busy/rsp_valid glitch-free.
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // Output decode. The accept is combinational in IDLE and is gated by rst_n
  // so that it stays low while reset is held, even with requests pending.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;
  assign done_cnt  = done_cnt_q;

endmodule
